// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Segment patterns {a,b,c,d,e,f,g,0} indexed by hex value; entry 15 is leftmost.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble plus decimal point to segment pattern.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern_c
);

  assign pattern_c = {SEG_TABLE[nibble][7:1], dp};

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered display data,
// per-slot blanking gap and optional leading-zero suppression.
module seven_segment_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          SEL_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_blank,
  output logic                    pending,
  output logic                    frame_done,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ACT_LOW}};

  scan_state_e           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [VAL_W-1:0]      shadow_value, shadow_value_nxt;
  logic [NUM_DIGITS-1:0] shadow_dp, shadow_dp_nxt;
  logic [VAL_W-1:0]      disp_value, disp_value_nxt;
  logic [NUM_DIGITS-1:0] disp_dp, disp_dp_nxt;
  logic                  pending_nxt;
  logic                  frame_wrap;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;
  logic [3:0]            nibble_sel;
  logic                  dp_sel;
  logic [7:0]            pattern_c;

  // Digit i is suppressed when it and every more significant nibble are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (disp_value[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_blank & zero_above;
    end
  end

  assign nibble_sel = disp_value[{idx_nxt, 2'b00} +: 4];
  assign dp_sel     = disp_dp[idx_nxt];

  seven_seg_hex_decode u_decode (
    .nibble    (nibble_sel),
    .dp        (dp_sel),
    .pattern_c (pattern_c)
  );

  // Next-state, counters, buffer transfer and next output values.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    idx_nxt          = idx;
    frame_wrap       = 1'b0;
    shadow_value_nxt = shadow_value;
    shadow_dp_nxt    = shadow_dp;
    disp_value_nxt   = disp_value;
    disp_dp_nxt      = disp_dp;
    pending_nxt      = pending;
    seg_nxt          = SEG_OFF;
    sel_nxt          = SEL_OFF;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (enable) state_nxt = BLANK;
      end
      BLANK: begin
        if (cnt == BLANK_LAST) state_nxt = SHOW;
        cnt_nxt = cnt + CNT_W'(1);
      end
      SHOW: begin
        if (cnt == SLOT_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt    = '0;
            frame_wrap = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      idx_nxt    = '0;
      frame_wrap = 1'b0;
    end

    if (load) begin
      shadow_value_nxt = load_value;
      shadow_dp_nxt    = load_dp;
      pending_nxt      = 1'b1;
    end

    // A load landing on the wrap edge goes straight to the display.
    if (frame_wrap) begin
      pending_nxt = 1'b0;
      if (load) begin
        disp_value_nxt = load_value;
        disp_dp_nxt    = load_dp;
      end else if (pending) begin
        disp_value_nxt = shadow_value;
        disp_dp_nxt    = shadow_dp;
      end
    end

    if (state_nxt == SHOW) begin
      seg_nxt = lz_mask[idx_nxt] ? {7'b0, dp_sel} : pattern_c;
      sel_nxt = (NUM_DIGITS'(1) << idx_nxt) ^ SEL_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      seg_out      <= SEG_OFF;
      digit_sel    <= SEL_OFF;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shadow_value <= shadow_value_nxt;
      shadow_dp    <= shadow_dp_nxt;
      disp_value   <= disp_value_nxt;
      disp_dp      <= disp_dp_nxt;
      pending      <= pending_nxt;
      frame_done   <= frame_wrap;
      seg_out      <= seg_nxt;
      digit_sel    <= sel_nxt;
    end
  end

endmodule
